// File: rtl/rgb_scan_pkg.sv
// Shared types and constants for the RGB bubble-matrix column scanner.
// Holds the scan state enum, default parameter values and the col_sel OFF word.
package rgb_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam int DEF_COLS      = 8;
  localparam int DEF_ROWS      = 8;
  localparam int DEF_DWELL     = 1024;
  localparam int DEF_BLANK_CYC = 4;

  localparam int MAX_COLS = 64;
  localparam logic [MAX_COLS-1:0] COL_OFF = '1;

endpackage

// File: rtl/rgb_free_col_enc.sv
// Lowest-index empty-column priority encoder over a red/blue frame.
// Purely combinational; the parent registers the result.
module rgb_free_col_enc #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int CW   = $clog2(COLS)
) (
  input  logic [COLS*ROWS-1:0] red_i,
  input  logic [COLS*ROWS-1:0] blue_i,
  output logic [CW-1:0]        col_o,
  output logic                 valid_o
);

  always_comb begin
    col_o   = '0;
    valid_o = 1'b0;
    // Walk downward so the lowest empty column is the last one written.
    for (int c = COLS - 1; c >= 0; c--) begin
      if (~|(red_i[c*ROWS +: ROWS] | blue_i[c*ROWS +: ROWS])) begin
        col_o   = CW'(c);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_matrix_scanner.sv
// Double-buffered column-multiplexed red/blue LED matrix driver.
// Define RGB_SCAN_BLANK_EN to insert BLANK_CYC dark cycles after each column.
module rgb_matrix_scanner
  import rgb_scan_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int DWELL     = DEF_DWELL,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int CW        = $clog2(COLS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 frame_load,
  input  logic [COLS*ROWS-1:0] red_frame,
  input  logic [COLS*ROWS-1:0] blue_frame,
  output logic [COLS-1:0]      col_sel,
  output logic [ROWS-1:0]      red_row,
  output logic [ROWS-1:0]      blue_row,
  output logic [CW-1:0]        scan_col,
  output logic                 frame_done,
  output logic [CW-1:0]        free_col,
  output logic                 free_valid
);

  localparam int N    = COLS * ROWS;
  localparam int CNTW = $clog2(DWELL + BLANK_CYC + 1);

  localparam logic [CNTW-1:0] DW_LAST  = CNTW'(DWELL - 1);
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [COLS-1:0] OFF      = COL_OFF[COLS-1:0];
`ifdef RGB_SCAN_BLANK_EN
  localparam logic [CNTW-1:0] BL_LAST  = CNTW'(BLANK_CYC - 1);
`endif

  scan_state_e     state_q, state_d;
  logic [CW-1:0]   col_q, col_d, nxt_col;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            wrap;

  logic [N-1:0]    stg_r_q, stg_r_d, stg_b_q, stg_b_d;
  logic [N-1:0]    shd_r_q, shd_r_d, shd_b_q, shd_b_d;
  logic            pend_q, pend_d;

  logic [COLS-1:0] cs_q, cs_d;
  logic [ROWS-1:0] rr_q, rr_d, br_q, br_d;
  logic            fd_q, fd_d;
  logic [CW-1:0]   fc_q, enc_col;
  logic            fv_q, enc_valid;

  assign nxt_col = (col_q == COL_LAST) ? '0 : col_q + CW'(1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DRIVE;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DW_LAST) begin
          cnt_d = '0;
`ifdef RGB_SCAN_BLANK_EN
          state_d = BLANK;
`else
          col_d = nxt_col;
          wrap  = (col_q == COL_LAST);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
`ifdef RGB_SCAN_BLANK_EN
        if (cnt_q == BL_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
          col_d   = nxt_col;
          wrap    = (col_q == COL_LAST);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      col_d   = '0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end
  end

  always_comb begin
    stg_r_d = stg_r_q;
    stg_b_d = stg_b_q;
    shd_r_d = shd_r_q;
    shd_b_d = shd_b_q;
    pend_d  = pend_q;
    // Shadow only changes at a frame boundary or while idle: no tearing.
    if (frame_load) begin
      stg_r_d = red_frame;
      stg_b_d = blue_frame;
      if (wrap || state_q == IDLE) begin
        shd_r_d = red_frame;
        shd_b_d = blue_frame;
        pend_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (wrap && pend_q) begin
      shd_r_d = stg_r_q;
      shd_b_d = stg_b_q;
      pend_d  = 1'b0;
    end

    cs_d = OFF;
    rr_d = '0;
    br_d = '0;
    if (state_d == DRIVE) begin
      cs_d[col_d] = 1'b0;
      rr_d = shd_r_d[int'(col_d)*ROWS +: ROWS];
      br_d = shd_b_d[int'(col_d)*ROWS +: ROWS];
    end
    fd_d = wrap;
  end

  rgb_free_col_enc #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW)
  ) u_enc (
    .red_i   (shd_r_q),
    .blue_i  (shd_b_q),
    .col_o   (enc_col),
    .valid_o (enc_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      stg_r_q <= '0;
      stg_b_q <= '0;
      shd_r_q <= '0;
      shd_b_q <= '0;
      pend_q  <= 1'b0;
      cs_q    <= OFF;
      rr_q    <= '0;
      br_q    <= '0;
      fd_q    <= 1'b0;
      fc_q    <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      stg_r_q <= stg_r_d;
      stg_b_q <= stg_b_d;
      shd_r_q <= shd_r_d;
      shd_b_q <= shd_b_d;
      pend_q  <= pend_d;
      cs_q    <= cs_d;
      rr_q    <= rr_d;
      br_q    <= br_d;
      fd_q    <= fd_d;
      fc_q    <= enc_col;
      fv_q    <= enc_valid;
    end
  end

  assign col_sel    = cs_q;
  assign red_row    = rr_q;
  assign blue_row   = br_q;
  assign scan_col   = col_q;
  assign frame_done = fd_q;
  assign free_col   = fc_q;
  assign free_valid = fv_q;

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// Self-checking bench for rgb_matrix_scanner (COLS=8, ROWS=8, DWELL=4).
// Per-cycle scoreboard driven from a position-based scan model plus a vector table.
module tb_rgb_matrix_scanner;

  localparam int COLS      = 8;
  localparam int ROWS      = 8;
  localparam int DWELL     = 4;
  localparam int BLANK_CYC = 2;
`ifdef RGB_SCAN_BLANK_EN
  localparam int BL = BLANK_CYC;
`else
  localparam int BL = 0;
`endif
  localparam int S = DWELL + BL;
  localparam int P = COLS * S;

  logic        CLK = 1'b0;
  logic        RST, enable, frame_load;
  logic [63:0] red_frame, blue_frame;
  logic [7:0]  col_sel, red_row, blue_row;
  logic [2:0]  scan_col, free_col;
  logic        frame_done, free_valid;

  always #5 CLK = ~CLK;

  rgb_matrix_scanner #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .DWELL     (DWELL),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .frame_load (frame_load),
    .red_frame  (red_frame),
    .blue_frame (blue_frame),
    .col_sel    (col_sel),
    .red_row    (red_row),
    .blue_row   (blue_row),
    .scan_col   (scan_col),
    .frame_done (frame_done),
    .free_col   (free_col),
    .free_valid (free_valid)
  );

  typedef struct packed {
    logic [7:0] cs;
    logic [7:0] rr;
    logic [7:0] br;
    logic [2:0] sc;
    logic       fd;
    logic [2:0] fc;
    logic       fv;
  } out_t;

  typedef struct {
    logic [63:0] r;
    logic [63:0] b;
    logic [2:0]  fc;
    logic        fv;
  } fvec_t;

  out_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  bit          active = 1'b0;
  int          pos = 0;
  bit          pend = 1'b0;
  logic [63:0] sh_r = '0, sh_b = '0, st_r = '0, st_b = '0;

  function automatic logic [3:0] enc(input logic [63:0] r, input logic [63:0] b);
    logic [63:0] m;
    for (int c = 0; c < COLS; c++) begin
      m = (r | b) >> (c * ROWS);
      if (m[7:0] == 8'h00) return {1'b1, 3'(c)};
    end
    return 4'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic check_sb();
    out_t a, e;
    a.cs = col_sel; a.rr = red_row; a.br = blue_row; a.sc = scan_col;
    a.fd = frame_done; a.fc = free_col; a.fv = free_valid;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", phase);
      return;
    end
    e = sb.pop_front();
    if (a !== e) begin
      fails++;
      $display("FAIL %s pos%0d: got cs=%h rr=%h br=%h sc=%0d fd=%0b fc=%0d fv=%0b required cs=%h rr=%h br=%h sc=%0d fd=%0b fc=%0d fv=%0b",
               phase, pos, a.cs, a.rr, a.br, a.sc, a.fd, a.fc, a.fv,
               e.cs, e.rr, e.br, e.sc, e.fd, e.fc, e.fv);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic ld,
                      input logic [63:0] r, input logic [63:0] b);
    out_t e;
    logic [3:0] f;
    bit was_idle, bnd;
    int col, slot;
    RST = rst; enable = en; frame_load = ld;
    red_frame = r; blue_frame = b;
    e = '0;
    e.cs = 8'hFF;
    if (rst) begin
      active = 0; pos = 0; pend = 0;
      sh_r = '0; sh_b = '0; st_r = '0; st_b = '0;
    end else begin
      f = enc(sh_r, sh_b);
      was_idle = !active;
      if (!en) begin
        active = 0; pos = 0;
      end else if (was_idle) begin
        active = 1; pos = 0;
      end else begin
        pos++;
      end
      bnd = active && !was_idle && (pos % P == 0);
      if (ld) begin
        st_r = r; st_b = b;
        if (was_idle || bnd) begin
          sh_r = r; sh_b = b; pend = 0;
        end else begin
          pend = 1;
        end
      end else if (bnd && pend) begin
        sh_r = st_r; sh_b = st_b; pend = 0;
      end
      e.fc = f[2:0];
      e.fv = f[3];
      if (active) begin
        col  = (pos / S) % COLS;
        slot = pos % S;
        e.sc = 3'(col);
        e.fd = bnd;
        if (slot < DWELL) begin
          e.cs = ~(8'h01 << col);
          e.rr = 8'(sh_r >> (col * ROWS));
          e.br = 8'(sh_b >> (col * ROWS));
        end
      end
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    check_sb();
    frame_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0, '0);
  endtask

  task automatic run_to(input int c, input int s);
    for (int i = 0; i < 2 * P; i++) begin
      if (active && ((pos % P) / S == c) && (pos % S == s)) break;
      step(0, 1, 0, '0, '0);
    end
  endtask

  localparam logic [63:0] R1 = 64'h0000_0000_A500_0000;
  localparam logic [63:0] R2 = 64'h0000_0000_5A00_0000;
  localparam logic [63:0] B2 = 64'h0000_0000_0000_003C;
  localparam logic [63:0] R3 = 64'h0000_0000_0000_0077;
  localparam logic [63:0] B3 = 64'h0000_0000_0000_0011;

  initial begin
    fvec_t tbl[6];
    int nfd, na5, nfe;
    tbl[0] = '{r: 64'h0000_0000_0000_8001, b: 64'h0, fc: 3'd2, fv: 1'b1};
    tbl[1] = '{r: 64'h0, b: 64'h0101_0101_0101_0101, fc: 3'd0, fv: 1'b0};
    tbl[2] = '{r: 64'h0, b: 64'h0, fc: 3'd0, fv: 1'b1};
    tbl[3] = '{r: 64'h00FF_FFFF_FFFF_FFFF, b: 64'h0, fc: 3'd7, fv: 1'b1};
    tbl[4] = '{r: 64'h0000_0000_0000_00FF, b: 64'h0000_0000_1000_0000, fc: 3'd1, fv: 1'b1};
    tbl[5] = '{r: 64'hFFFF_FFFF_FFFF_FF00, b: 64'h0, fc: 3'd0, fv: 1'b1};

    RST = 1'b1; enable = 1'b0; frame_load = 1'b0;
    red_frame = '0; blue_frame = '0;

    phase = "reset0";
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    chk("reset_col_sel", col_sel, 8'hFF);
    chk("reset_valid", free_valid, 1'b0);

    phase = "idle_load";
    step(0, 0, 1, R1, '0);

    phase = "scan";
    nfd = 0; na5 = 0;
    for (int i = 0; i < 2 * P + 1; i++) begin
      step(0, 1, 0, '0, '0);
      if (frame_done) nfd++;
      if (red_row == 8'hA5) na5++;
    end
    chk("scan_fd_count", nfd, 2);
    chk("scan_a5_cycles", na5, 2 * DWELL);

    phase = "tear";
    run_to(2, 1);
    step(0, 1, 1, R2, B2);
    run_to(3, 0);
    chk("tear_old_col3", red_row, 8'hA5);
    run_to(0, 0);
    chk("tear_new_col0_blue", blue_row, 8'h3C);
    run_to(3, 0);
    chk("tear_new_col3", red_row, 8'h5A);

    phase = "wrap_load";
    for (int i = 0; i < P; i++) begin
      if ((pos + 1) % P == 0) break;
      step(0, 1, 0, '0, '0);
    end
    step(0, 1, 1, R3, B3);
    chk("wrap_load_red", red_row, 8'h77);
    chk("wrap_load_blue", blue_row, 8'h11);
    chk("wrap_load_fd", frame_done, 1'b1);
    run(3);

    phase = "en_drop";
    run_to(5, 1);
    step(0, 0, 0, '0, '0);
    chk("drop_col_sel", col_sel, 8'hFF);
    chk("drop_scan_col", scan_col, 3'd0);
    chk("drop_fd", frame_done, 1'b0);
    step(0, 0, 0, '0, '0);
    nfe = 0;
    for (int i = 0; i < DWELL; i++) begin
      step(0, 1, 0, '0, '0);
      if (col_sel == 8'hFE) nfe++;
    end
    chk("reenable_col0_dwell", nfe, DWELL);
    run(P);

    phase = "reset_mid";
    run_to(2, 1);
    step(1, 1, 0, '0, '0);
    step(1, 1, 0, '0, '0);
    chk("rst_col_sel", col_sel, 8'hFF);
    chk("rst_rows", {red_row, blue_row}, 16'h0);
    chk("rst_scan_col", scan_col, 3'd0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_free_valid", free_valid, 1'b0);
    run(S + 2);

    phase = "free_tbl";
    step(0, 0, 0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, tbl[i].r, tbl[i].b);
      step(0, 0, 0, '0, '0);
      chk($sformatf("free_col_%0d", i), free_col, tbl[i].fc);
      chk($sformatf("free_valid_%0d", i), free_valid, tbl[i].fv);
    end
    run(P + 2);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rgb_matrix_scanner.md
Name: rgb_matrix_scanner

Overview:
Parametrised column-multiplexed driver for the red/blue LED bubble matrix. It double-buffers a full red and blue frame, scans the columns one at a time with a programmable dwell, and drives active-low column selects plus red/blue row data. It also reports the lowest-index empty column (no red or blue pixel lit), registered, for the game logic. It sits between game-state logic and the board LED pins.

Parameters:
COLS, 8, number of matrix columns (≥2)
ROWS, 8, number of rows per column
DWELL, 1024, clock cycles each column is driven (≥2)
BLANK_CYC, 4, blanking cycles between columns (used only with RGB_SCAN_BLANK_EN, ≥1)
CW, $clog2(COLS), derived column index width, not overridden

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
enable  in  1  scan enable; low forces IDLE
frame_load  in  1  single-cycle strobe, capture red_frame/blue_frame into staging
red_frame  in  COLS*ROWS  red pixels, bit c*ROWS+r = column c, row r
blue_frame  in  COLS*ROWS  blue pixels, same layout
col_sel  out  COLS  one-hot-low column select, all ones = off
red_row  out  ROWS  red row data for driven column, active-high
blue_row  out  ROWS  blue row data for driven column
scan_col  out  CW  index of column currently driven
frame_done  out  1  one-cycle pulse when last column's dwell ends
free_col  out  CW  lowest column with no lit pixel in shadow frame
free_valid  out  1  1 if any column is empty

Behaviour:
- Clock CLK, reset RST: one clock; reset is synchronous and active-high. All outputs registered.
- Reset values: col_sel all ones, red_row/blue_row 0, scan_col 0, frame_done 0, free_col 0, free_valid 0, staging/shadow 0, load_pending 0, dwell counter 0, state IDLE. Reset mid-scan takes effect on the next edge and has priority over everything.
- States: IDLE, DRIVE (plus BLANK with feature).
- IDLE: outputs off. When enable is sampled 1, go to DRIVE with scan_col=0. col_sel=~1 is visible from the following cycle, giving 1 cycle latency.
- DRIVE: col_sel[scan_col]=0, others 1. Rows come from the shadow bits [scan_col*ROWS +: ROWS]. The counter counts 0..DWELL-1. At DWELL-1 it clears and the block advances to scan_col+1.
- Wrap at COLS-1: return to column 0. frame_done=1 for exactly one cycle, coincident with the first cycle of column 0.
- enable low in any state: next cycle goes to IDLE, outputs off, scan_col 0, counter 0. There is no frame_done. Shadow, staging and load_pending are kept.
- frame_load: captures inputs into staging and sets load_pending. At the frame boundary (wrap), staging is copied to shadow and load_pending is cleared. The shadow never changes mid-frame, so there is no tearing.
- Simultaneous frame_load and wrap: the inputs go directly into shadow and load_pending stays 0.
- Load while in IDLE: copied to shadow immediately on the next cycle.
- Repeated loads before a boundary: the last one wins.
- free_col: priority encoder over the shadow. A column is empty if its red|blue bits are all 0, and the lowest index wins. The result is registered with 1-cycle latency after a shadow update. If all columns are occupied: free_valid=0 and free_col=0.

Optional Feature:
Macro RGB_SCAN_BLANK_EN.
- Defined: adds BLANK state after each column's dwell (including the wrap), lasting BLANK_CYC cycles with col_sel all ones and rows 0. This is anti-ghosting. frame_done pulses on entry to column 0 after the blank. Frame period is COLS*(DWELL+BLANK_CYC).
- Undefined: columns switch directly, period is COLS*DWELL, and BLANK_CYC is ignored.

Decomposition:
- Package rgb_scan_pkg holds the state enum (IDLE, DRIVE, BLANK), default parameter constants, and the col_sel OFF constant (all ones).
- Sub-module rgb_free_col_enc: parametrised lowest-empty-column priority encoder (COLS, ROWS), combinational, registered in the parent.

Test Plan:
- Reset: RST=1 for 2 cycles mid-DRIVE (COLS=8, DWELL=4) -> col_sel=8'hFF, rows 0, scan_col 0, free_valid 0, frame_done 0.
- Scan: load red column 3 = 8'hA5, enable=1 -> col_sel FE,FD,FB,F7,... each for 4 cycles. red_row=A5 only while col_sel=F7. frame_done pulses every 32 cycles.
- Tear-free: second frame_load during column 2 -> rows keep the old frame through column 7, new data appears from column 0 of the next pass. Also load on the wrap cycle -> applied directly.
- free_col: columns 0,1 lit, others empty -> free_col=2, free_valid=1. All 8 columns have one blue pixel -> free_valid=0, free_col=0.
- enable drop mid column 5 -> next cycle col_sel=FF, scan_col=0, no frame_done. Re-enable -> column 0 full dwell.
- With RGB_SCAN_BLANK_EN, BLANK_CYC=2 -> 2 cycles of col_sel=FF between columns, frame_done period 48 cycles.
